mutex_lock_ctrl: RTL and testbench
==================================

Name: mutex_lock_ctrl

Overview:
Ownership tracker downstream of the mutex arbiter. Latches the one-hot grant issued by the arbiter into a held lock. Keeps the lock until the owner releases it or a hold-timeout watchdog revokes it. Masks requests fed back to the arbiter while the resource is owned, so the arbiter only arbitrates when the resource is free.

Parameters:
N, 3, number of requesters (2..16)
MAX_HOLD, 64, maximum cycles a lock may be held before forced revoke; 0 disables timeout
ID_W, 2, width of owner_id; must satisfy 2^ID_W >= N

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
req  in  N  raw per-requester lock requests
arb_req  out  N  masked requests to arbiter
grant_in  in  N  one-hot grant from arbiter
release  in  N  per-requester release strobes
lock_grant  out  N  one-hot: requester currently owns lock
owner_valid  out  1  lock is held
owner_id  out  ID_W  index of owner, 0 when not held
timeout  out  1  one-cycle pulse on forced revoke
protocol_err  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset (rst=0, async): state IDLE; lock_grant=0, owner_valid=0, owner_id=0, timeout=0, protocol_err=0, hold counter=0.
- FSM states: IDLE, LOCKED, COOLDOWN. All outputs except arb_req are registered.
- arb_req = req when state==IDLE, else 0. It is combinational from the registered state.
- IDLE, grant_in!=0:
  - Next edge: LOCKED, owner = lowest set index of grant_in.
  - lock_grant = one-hot(owner), owner_valid=1, hold counter=1.
  - Latency grant_in -> lock_grant is 1 cycle.
- IDLE, grant_in has more than one bit set: lowest index wins, and protocol_err pulses on the same edge.
- LOCKED:
  - Hold counter increments each cycle and saturates at its maximum.
  - release[owner]=1: next edge -> COOLDOWN; lock_grant=0, owner_valid=0, owner_id=0, counter=0.
  - release of a non-owner bit: ignored for ownership; protocol_err pulses.
  - grant_in!=0 while LOCKED: ignored; protocol_err pulses.
  - req changes while LOCKED: ignored. The lock persists until release or timeout.
- Timeout (MAX_HOLD>0): in LOCKED, if counter==MAX_HOLD and release[owner]=0:
  - Next edge -> COOLDOWN, outputs cleared as for release, timeout=1 for exactly one cycle.
  - If release[owner]=1 in that same cycle, release wins and timeout stays 0.
- COOLDOWN: exactly one cycle with arb_req=0, then unconditionally IDLE. This gives the arbiter one cycle to retire the stale grant. grant_in during COOLDOWN is ignored with no error.
- Sequence timing: owner releases at cycle t -> arb_req unmasked at t+2 -> earliest new lock_grant at t+3, assuming a combinational arbiter grant.
- Widths: hold counter is clog2(MAX_HOLD+1) bits, minimum 1.
- Errors: protocol_err and timeout are pulses, never sticky. Multiple error causes in one cycle give a single pulse.
- Reset mid-lock: all outputs clear immediately (asynchronously). No timeout or error pulse is generated.

Optional Feature:
MUTEX_LOCK_STATS_EN
- Defined: adds outputs acq_count[15:0] (increments on each IDLE->LOCKED) and to_count[15:0] (increments on each timeout revoke). Both saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset release, req=3'b010, grant_in=3'b010 at cycle 1 -> cycle 2 lock_grant=010, owner_id=1, owner_valid=1; arb_req=000 from cycle 2.
2. Owner 1 holds, release=3'b010 at cycle 5 -> cycle 6 lock_grant=000, state COOLDOWN, arb_req=000; cycle 7 arb_req=req.
3. MAX_HOLD=4, lock at cycle 2, no release -> timeout=1 and lock_grant=000 at cycle 6; arb_req unmasked at cycle 7.
4. MAX_HOLD=4, release[owner] in the cycle counter==4 -> normal release, timeout stays 0; to_count unchanged (with MUTEX_LOCK_STATS_EN).
5. IDLE, grant_in=3'b101 -> owner_id=0, lock_grant=001, protocol_err pulse. While locked, release=3'b100 -> protocol_err pulse, lock retained.
6. Lock held, rst driven 0 mid-cycle -> outputs 0 before the next clk edge. After rst=1, grant_in=3'b100 -> owner_id=2 after 1 cycle; acq_count increments per lock.

Source files
------------

// File: rtl/mutex_lock_ctrl_if.sv
// Lock-control bundle between requesters/arbiter and mutex_lock_ctrl.
// MUTEX_LOCK_STATS_EN adds the acq_count/to_count statistics outputs.
interface mutex_lock_ctrl_if #(
  parameter int N    = 3,
  parameter int ID_W = 2
);
  logic [N-1:0]    req;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    grant_in;
  logic [N-1:0]    release_stb;
  logic [N-1:0]    lock_grant;
  logic            owner_valid;
  logic [ID_W-1:0] owner_id;
  logic            timeout;
  logic            protocol_err;
`ifdef MUTEX_LOCK_STATS_EN
  logic [15:0]     acq_count;
  logic [15:0]     to_count;

  modport master (
    output req, grant_in, release_stb,
    input  arb_req, lock_grant, owner_valid, owner_id, timeout, protocol_err,
    input  acq_count, to_count
  );
  modport slave (
    input  req, grant_in, release_stb,
    output arb_req, lock_grant, owner_valid, owner_id, timeout, protocol_err,
    output acq_count, to_count
  );
`else
  modport master (
    output req, grant_in, release_stb,
    input  arb_req, lock_grant, owner_valid, owner_id, timeout, protocol_err
  );
  modport slave (
    input  req, grant_in, release_stb,
    output arb_req, lock_grant, owner_valid, owner_id, timeout, protocol_err
  );
`endif
endinterface

// File: rtl/mutex_lock_ctrl.sv
// Holds the arbiter's one-hot grant as a lock until owner release or hold timeout.
// Optional MUTEX_LOCK_STATS_EN adds saturating acquire/timeout counters.
module mutex_lock_ctrl #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 64,
  parameter int ID_W     = 2
) (
  input logic               clk,
  input logic               rst,
  mutex_lock_ctrl_if.slave  bus
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_COOLDOWN} state_t;

  state_t          state;
  logic [N-1:0]    lock_grant_q;
  logic            owner_valid_q;
  logic [ID_W-1:0] owner_id_q;
  logic            timeout_q;
  logic            protocol_err_q;
  logic [CNT_W-1:0] hold_cnt;

  logic [N-1:0]    grant_low;
  logic [ID_W-1:0] grant_idx;
  logic            grant_multi;
  logic            owner_rel;
  logic            stray_rel;
  logic            timeout_hit;

  // Isolate the lowest set grant bit; anything left over means a multi-hot grant.
  assign grant_low   = bus.grant_in & (~bus.grant_in + N'(1));
  assign grant_multi = |(bus.grant_in & ~grant_low);
  assign owner_rel   = |(bus.release_stb & lock_grant_q);
  assign stray_rel   = |(bus.release_stb & ~lock_grant_q);
  assign timeout_hit = (MAX_HOLD > 0) && (hold_cnt == CNT_LIMIT);

  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.grant_in[i]) grant_idx = ID_W'(i);
    end
  end

`ifdef MUTEX_LOCK_STATS_EN
  logic [15:0] acq_cnt;
  logic [15:0] to_cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      lock_grant_q   <= '0;
      owner_valid_q  <= 1'b0;
      owner_id_q     <= '0;
      timeout_q      <= 1'b0;
      protocol_err_q <= 1'b0;
      hold_cnt       <= '0;
`ifdef MUTEX_LOCK_STATS_EN
      acq_cnt        <= '0;
      to_cnt         <= '0;
`endif
    end else begin
      timeout_q      <= 1'b0;
      protocol_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|bus.grant_in) begin
            state          <= ST_LOCKED;
            lock_grant_q   <= grant_low;
            owner_id_q     <= grant_idx;
            owner_valid_q  <= 1'b1;
            hold_cnt       <= CNT_W'(1);
            protocol_err_q <= grant_multi;
`ifdef MUTEX_LOCK_STATS_EN
            if (acq_cnt != 16'hFFFF) acq_cnt <= acq_cnt + 16'd1;
`endif
          end
        end
        ST_LOCKED: begin
          protocol_err_q <= stray_rel | (|bus.grant_in);
          // Owner release takes priority over a timeout landing on the same cycle.
          if (owner_rel || timeout_hit) begin
            state         <= ST_COOLDOWN;
            lock_grant_q  <= '0;
            owner_valid_q <= 1'b0;
            owner_id_q    <= '0;
            hold_cnt      <= '0;
            if (!owner_rel) begin
              timeout_q <= 1'b1;
`ifdef MUTEX_LOCK_STATS_EN
              if (to_cnt != 16'hFFFF) to_cnt <= to_cnt + 16'd1;
`endif
            end
          end else if (hold_cnt != CNT_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        ST_COOLDOWN: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  assign bus.arb_req      = (state == ST_IDLE) ? bus.req : '0;
  assign bus.lock_grant   = lock_grant_q;
  assign bus.owner_valid  = owner_valid_q;
  assign bus.owner_id     = owner_id_q;
  assign bus.timeout      = timeout_q;
  assign bus.protocol_err = protocol_err_q;
`ifdef MUTEX_LOCK_STATS_EN
  assign bus.acq_count    = acq_cnt;
  assign bus.to_count     = to_cnt;
`endif

endmodule

// File: tb/tb_mutex_lock_ctrl.sv
// Directed self-checking bench for mutex_lock_ctrl (N=3, MAX_HOLD=4).
module tb_mutex_lock_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
`ifdef MUTEX_LOCK_STATS_EN
  int   exp_acq = 0;
  int   exp_to  = 0;
`endif

  always #5 clk = ~clk;

  mutex_lock_ctrl_if #(.N(3), .ID_W(2)) bus ();

  mutex_lock_ctrl #(.N(3), .MAX_HOLD(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset;
    bus.req = 3'b000; bus.grant_in = 3'b000; bus.release_stb = 3'b000;
    step(2);
    chk("rst_lock_grant", 32'(bus.lock_grant), 32'h0);
    chk("rst_owner_valid", 32'(bus.owner_valid), 32'h0);
    chk("rst_owner_id", 32'(bus.owner_id), 32'h0);
    chk("rst_flags", {30'd0, bus.timeout, bus.protocol_err}, 32'h0);
    #2 rst = 1'b1;
    step(1);
    bus.req = 3'b010;
    #1;
    chk("idle_arb_req", 32'(bus.arb_req), 32'h2);
  endtask

  task automatic test_lock_release;
    bus.grant_in = 3'b010;
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    chk("lock_grant", 32'(bus.lock_grant), 32'h2);
    chk("lock_owner_id", 32'(bus.owner_id), 32'h1);
    chk("lock_owner_valid", 32'(bus.owner_valid), 32'h1);
    chk("lock_arb_masked", 32'(bus.arb_req), 32'h0);
    chk("lock_no_err", 32'(bus.protocol_err), 32'h0);
    bus.req = 3'b011;
    step(2);
    chk("hold_req_change", 32'(bus.lock_grant), 32'h2);
    bus.release_stb = 3'b010;
    step(1);
    bus.release_stb = 3'b000;
    chk("rel_lock_grant", 32'(bus.lock_grant), 32'h0);
    chk("rel_owner_valid", 32'(bus.owner_valid), 32'h0);
    chk("rel_owner_id", 32'(bus.owner_id), 32'h0);
    chk("cooldown_arb_masked", 32'(bus.arb_req), 32'h0);
    chk("rel_no_timeout", 32'(bus.timeout), 32'h0);
    step(1);
    chk("idle_arb_unmasked", 32'(bus.arb_req), 32'h3);
  endtask

  task automatic test_timeout;
    bus.req = 3'b001; bus.grant_in = 3'b001;
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    step(3);
    chk("to_held_at_limit", 32'(bus.lock_grant), 32'h1);
    chk("to_not_yet", 32'(bus.timeout), 32'h0);
    step(1);
`ifdef MUTEX_LOCK_STATS_EN
    exp_to++;
`endif
    chk("to_pulse", 32'(bus.timeout), 32'h1);
    chk("to_lock_cleared", 32'(bus.lock_grant), 32'h0);
    chk("to_valid_cleared", 32'(bus.owner_valid), 32'h0);
    chk("to_arb_masked", 32'(bus.arb_req), 32'h0);
    chk("to_no_err", 32'(bus.protocol_err), 32'h0);
    step(1);
    chk("to_pulse_end", 32'(bus.timeout), 32'h0);
    chk("to_arb_unmasked", 32'(bus.arb_req), 32'h1);
`ifdef MUTEX_LOCK_STATS_EN
    chk("to_count", 32'(bus.to_count), 32'(exp_to));
`endif
  endtask

  task automatic test_release_at_limit;
    bus.req = 3'b100; bus.grant_in = 3'b100;
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    step(3);
    bus.release_stb = 3'b100;
    step(1);
    bus.release_stb = 3'b000;
    chk("lim_no_timeout", 32'(bus.timeout), 32'h0);
    chk("lim_lock_cleared", 32'(bus.lock_grant), 32'h0);
    step(1);
    chk("lim_no_timeout_late", 32'(bus.timeout), 32'h0);
`ifdef MUTEX_LOCK_STATS_EN
    chk("lim_to_count", 32'(bus.to_count), 32'(exp_to));
`endif
  endtask

  task automatic test_protocol_err;
    bus.req = 3'b101; bus.grant_in = 3'b101;
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    chk("multi_owner_id", 32'(bus.owner_id), 32'h0);
    chk("multi_lock_grant", 32'(bus.lock_grant), 32'h1);
    chk("multi_err", 32'(bus.protocol_err), 32'h1);
    step(1);
    chk("multi_err_pulse", 32'(bus.protocol_err), 32'h0);
    bus.release_stb = 3'b100;
    step(1);
    bus.release_stb = 3'b000;
    chk("stray_rel_err", 32'(bus.protocol_err), 32'h1);
    chk("stray_rel_kept", 32'(bus.lock_grant), 32'h1);
    bus.grant_in = 3'b110;
    step(1);
    bus.grant_in = 3'b000;
    chk("locked_grant_err", 32'(bus.protocol_err), 32'h1);
    chk("locked_grant_kept", 32'(bus.owner_id), 32'h0);
    bus.release_stb = 3'b001;
    step(1);
    bus.release_stb = 3'b000;
    chk("multi_rel_clean", 32'(bus.protocol_err), 32'h0);
    step(1);
  endtask

  task automatic test_back_to_back;
    bus.req = 3'b011; bus.grant_in = 3'b001;
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    bus.release_stb = 3'b001;
    step(1);
    bus.release_stb = 3'b000;
    bus.grant_in = 3'b010;
    step(1);
    chk("b2b_cooldown_ignored", 32'(bus.lock_grant), 32'h0);
    chk("b2b_cooldown_no_err", 32'(bus.protocol_err), 32'h0);
    chk("b2b_arb_unmasked", 32'(bus.arb_req), 32'h3);
    step(1);
    bus.grant_in = 3'b000;
`ifdef MUTEX_LOCK_STATS_EN
    exp_acq++;
`endif
    chk("b2b_new_lock", 32'(bus.lock_grant), 32'h2);
    chk("b2b_new_owner", 32'(bus.owner_id), 32'h1);
`ifdef MUTEX_LOCK_STATS_EN
    chk("b2b_acq_count", 32'(bus.acq_count), 32'(exp_acq));
`endif
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b0;
    #1;
    chk("arst_lock_grant", 32'(bus.lock_grant), 32'h0);
    chk("arst_owner_valid", 32'(bus.owner_valid), 32'h0);
    chk("arst_owner_id", 32'(bus.owner_id), 32'h0);
    chk("arst_flags", {30'd0, bus.timeout, bus.protocol_err}, 32'h0);
    step(1);
    #2 rst = 1'b1;
    bus.req = 3'b100; bus.grant_in = 3'b100;
    step(1);
    bus.grant_in = 3'b000;
    chk("post_rst_owner_id", 32'(bus.owner_id), 32'h2);
    chk("post_rst_lock", 32'(bus.lock_grant), 32'h4);
    chk("post_rst_flags", {30'd0, bus.timeout, bus.protocol_err}, 32'h0);
`ifdef MUTEX_LOCK_STATS_EN
    chk("post_rst_acq_count", 32'(bus.acq_count), 32'h1);
    chk("post_rst_to_count", 32'(bus.to_count), 32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_lock_release();
    test_timeout();
    test_release_at_limit();
    test_protocol_err();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
